// File: rtl/dsp_pkg.sv
// dsp_pkg: shared types and constants for the DSP pipeline blocks.
//   butterfly_state_t : status encoding reported on bf_state
//   FRAME_CNT_W       : width of the output frame counter
package dsp_pkg;

    typedef enum logic [1:0] {
        BF_IDLE = 2'b00,
        BF_CALC = 2'b01,
        BF_DONE = 2'b10,
        BF_ERR  = 2'b11
    } butterfly_state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/inv_fft_butterfly_if.sv
// inv_fft_butterfly_if: streaming bus of the inverse butterfly.
//   in_valid/in_ready/real_in/imag_in    : input pair (s = a+b, d = a-b)
//   out_valid/out_ready/real_out/imag_out: recovered pair (a, b)
//   master : producer/consumer side (testbench or neighbouring blocks)
//   slave  : the butterfly itself
interface inv_fft_butterfly_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] real_in;
    logic [DATA_WIDTH-1:0] imag_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] real_out;
    logic [DATA_WIDTH-1:0] imag_out;

    modport master (
        output in_valid, real_in, imag_in, out_ready,
        input  in_ready, out_valid, real_out, imag_out
    );

    modport slave (
        input  in_valid, real_in, imag_in, out_ready,
        output in_ready, out_valid, real_out, imag_out
    );
endinterface

// File: rtl/ibf_pipe_stage.sv
// ibf_pipe_stage: one stall-able pipeline register with a valid bit.
//   clk, rst_n : clock, asynchronous active-low reset (clears valid and data)
//   en_i       : load enable; when low the stage holds
//   valid_i    : valid bit to capture
//   data_i     : payload to capture
//   valid_o    : registered valid
//   data_o     : registered payload
module ibf_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/inv_fft_butterfly.sv
// inv_fft_butterfly: radix-2 inverse butterfly, recovers a=(s+d)/2 and
// b=(s-d)/2 from a sum/difference pair. Two-stage stall-able pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : streaming in/out handshake (inv_fft_butterfly_if.slave)
//   clear_err  : pulse, leaves the sticky error state
//   parity_err : LSB parity of s and d disagreed for the current output
//   frame_done : pulse on the last output handshake of a frame
//   frame_cnt  : output handshakes so far in the current frame
//   bf_state   : butterfly_state_t status
//   err_count  : errored output handshakes, saturating (only with
//                INV_BUTTERFLY_STATS_EN defined)
//
// State table:
//   BF_IDLE | pipeline empty
//   BF_CALC | a pair is in stage 1 or at the output
//   BF_DONE | one cycle after a frame completed
//   BF_ERR  | sticky: an output carried a parity error, until clear_err
module inv_fft_butterfly
    import dsp_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BUTTERFLY_ID = 0,
    parameter int FRAME_LEN    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    inv_fft_butterfly_if.slave     bus,
    input  logic                   clear_err,
    output logic                   parity_err,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
`ifdef INV_BUTTERFLY_STATS_EN
    output logic [15:0]            err_count,
`endif
    output butterfly_state_t       bf_state
);
    localparam int DW = DATA_WIDTH;
    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(FRAME_LEN - 1);

    // BUTTERFLY_ID is only an instance label; reject nonsense values early.
    if (FRAME_LEN < 2 || FRAME_LEN > 65535 || BUTTERFLY_ID < 0) begin : g_param_chk
        $error("inv_fft_butterfly: illegal FRAME_LEN or BUTTERFLY_ID");
    end

    logic pipe_en;
    logic out_hs;
    logic err_hs;
    logic any_valid;

    // Sign-extend by one bit so s+d and s-d can never overflow.
    logic signed [DW:0] s_ext;
    logic signed [DW:0] d_ext;
    logic signed [DW:0] sum_in;
    logic signed [DW:0] dif_in;

    logic                v1;
    logic [2*DW+2:0]     s1_data;
    logic [DW:0]         sum1;
    logic [DW:0]         dif1;
    logic                pm1;
    logic [2*DW:0]       s2_data;
    logic                unused_lsbs;

    assign pipe_en     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = pipe_en;
    assign out_hs      = bus.out_valid && bus.out_ready;
    assign err_hs      = out_hs && parity_err;
    assign any_valid   = v1 || bus.out_valid;

    assign s_ext  = {bus.real_in[DW-1], bus.real_in};
    assign d_ext  = {bus.imag_in[DW-1], bus.imag_in};
    assign sum_in = s_ext + d_ext;
    assign dif_in = s_ext - d_ext;

    // Loading stage 1 with in_valid while pipe_en is high records exactly
    // the input handshake.
    ibf_pipe_stage #(.WIDTH(2*DW+3)) u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (pipe_en),
        .valid_i (bus.in_valid),
        .data_i  ({sum_in, dif_in, bus.real_in[0] ^ bus.imag_in[0]}),
        .valid_o (v1),
        .data_o  (s1_data)
    );

    assign sum1 = s1_data[2*DW+2:DW+2];
    assign dif1 = s1_data[DW+1:1];
    assign pm1  = s1_data[0];

    // Dropping the LSB is the arithmetic shift right by one.
    assign unused_lsbs = sum1[0] ^ dif1[0];

    ibf_pipe_stage #(.WIDTH(2*DW+1)) u_stage2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (pipe_en),
        .valid_i (v1),
        .data_i  ({sum1[DW:1], dif1[DW:1], pm1}),
        .valid_o (bus.out_valid),
        .data_o  (s2_data)
    );

    assign bus.real_out = s2_data[2*DW:DW+1];
    assign bus.imag_out = s2_data[DW:1];
    assign parity_err   = s2_data[0];

    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_d;
    logic                   frame_last;

    assign frame_last = (frame_cnt_q == FRAME_LAST);
    assign frame_done = out_hs && frame_last;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (out_hs) begin
            frame_cnt_d = frame_last ? '0 : frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;

    butterfly_state_t state_q;
    butterfly_state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BF_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A fresh error wins over a simultaneous clear_err.
    always_comb begin
        state_d = state_q;
        if (err_hs) begin
            state_d = BF_ERR;
        end else if (state_q == BF_ERR) begin
            if (clear_err) begin
                state_d = any_valid ? BF_CALC : BF_IDLE;
            end
        end else if (frame_done) begin
            state_d = BF_DONE;
        end else if (any_valid) begin
            state_d = BF_CALC;
        end else begin
            state_d = BF_IDLE;
        end
    end

    assign bf_state = state_q;

`ifdef INV_BUTTERFLY_STATS_EN
    logic [15:0] err_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else if (err_hs && err_count_q != 16'hFFFF) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_inv_fft_butterfly.sv
// tb_inv_fft_butterfly: directed self-checking bench for inv_fft_butterfly
// (DATA_WIDTH=16, FRAME_LEN=4). Inputs are driven and outputs sampled 1ns
// after the rising edge.
module tb_inv_fft_butterfly;
    import dsp_pkg::*;

    localparam int DW = 16;

    logic             clk;
    logic             rst_n;
    logic             clear_err;
    logic             parity_err;
    logic             frame_done;
    logic [15:0]      frame_cnt;
    butterfly_state_t bf_state;
`ifdef INV_BUTTERFLY_STATS_EN
    logic [15:0]      err_count;
`endif

    int n_checks = 0;
    int n_errs   = 0;

    inv_fft_butterfly_if #(.DATA_WIDTH(DW)) bus ();

    inv_fft_butterfly #(
        .DATA_WIDTH   (DW),
        .BUTTERFLY_ID (3),
        .FRAME_LEN    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .clear_err  (clear_err),
        .parity_err (parity_err),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
`ifdef INV_BUTTERFLY_STATS_EN
        .err_count  (err_count),
`endif
        .bf_state   (bf_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] s, input logic [DW-1:0] d);
        bus.in_valid = v;
        bus.real_in  = s;
        bus.imag_in  = d;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        clear_err     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    // stall test scoreboard: s = 4k+2, d = 2  ->  a = 2k+2, b = 2k
    localparam int NSTREAM = 12;

    initial begin
        int sent;
        int rcv;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;

        rst_n         = 1'b0;
        clear_err     = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0);
        #12;
        check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_real_out", {16'd0, bus.real_out}, 32'd0);
        check_eq("rst_imag_out", {16'd0, bus.imag_out}, 32'd0);
        check_eq("rst_parity", {31'd0, parity_err}, 32'd0);
        check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check_eq("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check_eq("rst_state", {30'd0, bf_state}, {30'd0, BF_IDLE});
        do_reset();
        check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // basic pair: s=8, d=2 -> a=5, b=3
        drive(1'b1, 16'h0008, 16'h0002);
        step();
        drive(1'b0, '0, '0);
        check_eq("basic_lat1_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        check_eq("basic_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("basic_real", {16'd0, bus.real_out}, 32'h0005);
        check_eq("basic_imag", {16'd0, bus.imag_out}, 32'h0003);
        check_eq("basic_parity", {31'd0, parity_err}, 32'd0);
        check_eq("basic_state", {30'd0, bf_state}, {30'd0, BF_CALC});

        // negative operands: s=3, d=-11 -> a=-4, b=7
        do_reset();
        drive(1'b1, 16'h0003, 16'hFFF5);
        step();
        drive(1'b0, '0, '0);
        step();
        check_eq("neg_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("neg_real", {16'd0, bus.real_out}, 32'h0000FFFC);
        check_eq("neg_imag", {16'd0, bus.imag_out}, 32'h0007);
        check_eq("neg_parity", {31'd0, parity_err}, 32'd0);

        // parity error: s=8, d=3 -> a=5, b=2, parity_err=1, sticky BF_ERR
        do_reset();
        drive(1'b1, 16'h0008, 16'h0003);
        step();
        drive(1'b0, '0, '0);
        step();
        check_eq("perr_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("perr_flag", {31'd0, parity_err}, 32'd1);
        check_eq("perr_real", {16'd0, bus.real_out}, 32'h0005);
        check_eq("perr_imag", {16'd0, bus.imag_out}, 32'h0002);
        drive(1'b1, 16'h0008, 16'h0002);
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq($sformatf("perr_sticky_%0d", i), {30'd0, bf_state}, {30'd0, BF_ERR});
        end
        check_eq("perr_clean_flag", {31'd0, parity_err}, 32'd0);
`ifdef INV_BUTTERFLY_STATS_EN
        check_eq("perr_err_count", {16'd0, err_count}, 32'd1);
`endif
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check_eq("perr_cleared", {30'd0, bf_state}, {30'd0, BF_CALC});
        drive(1'b0, '0, '0);

        // continuous stream with a 5-cycle downstream stall
        do_reset();
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 60 && rcv < NSTREAM; cyc++) begin
            bus.out_ready = !(cyc >= 4 && cyc < 9);
            if (sent < NSTREAM) begin
                drive(1'b1, DW'(4 * sent + 2), 16'h0002);
            end else begin
                drive(1'b0, '0, '0);
            end
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                check_eq($sformatf("stall_in_ready_c%0d", cyc), {31'd0, bus.in_ready}, 32'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                exp_a = DW'(2 * rcv + 2);
                exp_b = DW'(2 * rcv);
                check_eq($sformatf("stream_real_%0d", rcv), {16'd0, bus.real_out}, {16'd0, exp_a});
                check_eq($sformatf("stream_imag_%0d", rcv), {16'd0, bus.imag_out}, {16'd0, exp_b});
                rcv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sent++;
            end
            step();
        end
        check_eq("stream_count", rcv, NSTREAM);
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0);

        // frame of 4 outputs
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(2 * i), 16'h0000);
            step();
        end
        drive(1'b0, '0, '0);
        // now after the 4th capture edge: first output has been visible one cycle
        // re-align: outputs appear 2 edges after each capture, i.e. at edges 2..5
        // we are post-edge 4, so outputs #2 (cnt 2) ... rewind via explicit checks
        check_eq("frame_cnt_e4", {16'd0, frame_cnt}, 32'd2);
        check_eq("frame_done_e4", {31'd0, frame_done}, 32'd0);
        step();
        check_eq("frame_cnt_e5", {16'd0, frame_cnt}, 32'd3);
        check_eq("frame_done_e5", {31'd0, frame_done}, 32'd1);
        check_eq("frame_state_e5", {30'd0, bf_state}, {30'd0, BF_CALC});
        step();
        check_eq("frame_cnt_wrap", {16'd0, frame_cnt}, 32'd0);
        check_eq("frame_done_after", {31'd0, frame_done}, 32'd0);
        check_eq("frame_state_done", {30'd0, bf_state}, {30'd0, BF_DONE});
        step();
        check_eq("frame_state_idle", {30'd0, bf_state}, {30'd0, BF_IDLE});

        // reset with two pairs in flight
        do_reset();
        drive(1'b1, 16'h0010, 16'h0002);
        step();
        drive(1'b1, 16'h0020, 16'h0004);
        step();
        drive(1'b0, '0, '0);
        check_eq("inflight_valid", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("inflight_rst_drop", {31'd0, bus.out_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        check_eq("inflight_in_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq($sformatf("inflight_stale_%0d", i), {31'd0, bus.out_valid}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
